// File: rtl/aes_key_expander.sv
// AES-128/192/256 key schedule engine with round-key store.
// SubWord goes through a shared external S-box port of fixed latency.
module aes_key_expander #(
  parameter int SBOX_LAT = 1
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         load_key,
  input  logic [1:0]   key_len,
  input  logic [255:0] cipher_key,
  input  logic [3:0]   sel_round,
  output logic [127:0] round_key,
  output logic         sbox_req,
  output logic [31:0]  sbox_word_out,
  input  logic [31:0]  sbox_word_in,
  output logic         busy,
  output logic         expansion_done,
  output logic [3:0]   num_rounds
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_GEN   = 2'd1;
  localparam logic [1:0] S_SWAIT = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [1:0] LAT_M1 = 2'(SBOX_LAT - 1);

  logic [1:0]  state;
  logic [31:0] w [60];
  logic [5:0]  idx;
  logic [3:0]  nk;
  logic [3:0]  nr;
  logic [2:0]  kpos;
  logic [7:0]  rcon;
  logic [1:0]  wcnt;

  logic        load_ok;
  logic [3:0]  nk_new;
  logic [3:0]  nr_new;
  logic [31:0] prev;
  logic [31:0] back;
  logic [31:0] rot_word;
  logic        rot_pos;
  logic        mid_pos;
  logic        need_sub;
  logic        last_word;
  logic        kpos_last;
  logic        in_gen;
  logic        in_wait;
  logic        sample;
  logic        write_word;
  logic [31:0] temp;
  logic [31:0] new_word;
  logic        rd_ok;
  logic [5:0]  rd_base;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  assign load_ok = load_key && (key_len != 2'd3);

  always_comb begin
    nk_new = 4'd4;
    nr_new = 4'd10;
    unique case (1'b1)
      key_len == 2'd1: begin
        nk_new = 4'd6;
        nr_new = 4'd12;
      end
      key_len == 2'd2: begin
        nk_new = 4'd8;
        nr_new = 4'd14;
      end
      default: begin
        nk_new = 4'd4;
        nr_new = 4'd10;
      end
    endcase
  end

  assign in_gen  = (state == S_GEN);
  assign in_wait = (state == S_SWAIT);

  assign prev     = w[idx - 6'd1];
  assign back     = w[idx - {2'b00, nk}];
  assign rot_word = {prev[23:0], prev[31:24]};

  // kpos tracks i mod Nk so no divider is needed
  assign rot_pos   = (kpos == 3'd0);
  assign mid_pos   = (nk == 4'd8) && (kpos == 3'd4);
  assign need_sub  = rot_pos || mid_pos;
  assign kpos_last = ({1'b0, kpos} == (nk - 4'd1));
  assign last_word = (idx == {nr, 2'b11});

  assign sample     = in_wait && (wcnt == LAT_M1);
  assign write_word = (in_gen && !need_sub) || sample;

  always_comb begin
    temp = prev;
    if (sample) begin
      temp = sbox_word_in;
      if (rot_pos) temp = temp ^ {rcon, 24'h0};
    end
  end

  assign new_word = back ^ temp;

  assign sbox_req = in_gen && need_sub;

  always_comb begin
    sbox_word_out = 32'h0;
    if (sbox_req) sbox_word_out = rot_pos ? rot_word : prev;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_IDLE;
      idx   <= 6'd0;
      nk    <= 4'd0;
      nr    <= 4'd0;
      kpos  <= 3'd0;
      rcon  <= 8'h00;
      wcnt  <= 2'd0;
      for (int j = 0; j < 60; j++) w[j] <= 32'h0;
    end else if (load_ok) begin
      state <= S_GEN;
      idx   <= {2'b00, nk_new};
      nk    <= nk_new;
      nr    <= nr_new;
      kpos  <= 3'd0;
      rcon  <= 8'h01;
      wcnt  <= 2'd0;
      for (int j = 0; j < 8; j++) begin
        if (4'(j) < nk_new) w[j] <= cipher_key[255 - 32*j -: 32];
      end
    end else if (write_word) begin
      w[idx] <= new_word;
      idx    <= idx + 6'd1;
      kpos   <= kpos_last ? 3'd0 : kpos + 3'd1;
      if (rot_pos) rcon <= xtime(rcon);
      state  <= last_word ? S_DONE : S_GEN;
    end else if (sbox_req) begin
      state <= S_SWAIT;
      wcnt  <= 2'd0;
    end else if (in_wait) begin
      wcnt <= wcnt + 2'd1;
    end
  end

  // a load on this edge invalidates the store, so it never reads through
  assign rd_ok   = (state == S_DONE) && !load_ok && (sel_round <= nr);
  assign rd_base = {sel_round, 2'b00};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      round_key <= 128'h0;
    end else if (rd_ok) begin
      round_key <= {w[rd_base], w[rd_base + 6'd1],
                    w[rd_base + 6'd2], w[rd_base + 6'd3]};
    end else begin
      round_key <= 128'h0;
    end
  end

  assign busy           = in_gen || in_wait;
  assign expansion_done = (state == S_DONE);
  assign num_rounds     = nr;

endmodule

// File: tb/tb_aes_key_expander.sv
// Bench for aes_key_expander: two instances (S-box latency 1 and 3),
// queued expectations checked by a negedge monitor.
module tb_aes_key_expander;

  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16};

  localparam logic [255:0] K128 =
    {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
  localparam logic [255:0] K192 =
    {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
  localparam logic [255:0] K256 =
    256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

  typedef struct {
    int           due;
    bit           dut;
    string        name;
    logic [127:0] key;
    logic [3:0]   nr;
    bit           busy;
    bit           done;
    bit           sb;
    int           pulses;
  } exp_t;

  logic         clk;
  logic         reset_n;
  logic         load_a;
  logic         load_b;
  logic [1:0]   key_len;
  logic [255:0] cipher_key;
  logic [3:0]   sel_round;

  logic [127:0] a_rk, b_rk;
  logic         a_req, b_req;
  logic [31:0]  a_sw, b_sw;
  logic [31:0]  a_sin, b_sin;
  logic         a_busy, b_busy;
  logic         a_done, b_done;
  logic [3:0]   a_nr, b_nr;

  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;
  int   npa = 0;
  int   npb = 0;
  bit   fin = 0;
  bit   pda = 0;
  bit   pdb = 0;
  exp_t rq[$];
  int   dqa[$];
  int   dqb[$];

  aes_key_expander #(.SBOX_LAT(1)) dut_a (
    .clk(clk), .reset_n(reset_n), .load_key(load_a),
    .key_len(key_len), .cipher_key(cipher_key),
    .sel_round(sel_round), .round_key(a_rk),
    .sbox_req(a_req), .sbox_word_out(a_sw),
    .sbox_word_in(a_sin), .busy(a_busy),
    .expansion_done(a_done), .num_rounds(a_nr));

  aes_key_expander #(.SBOX_LAT(3)) dut_b (
    .clk(clk), .reset_n(reset_n), .load_key(load_b),
    .key_len(key_len), .cipher_key(cipher_key),
    .sel_round(sel_round), .round_key(b_rk),
    .sbox_req(b_req), .sbox_word_out(b_sw),
    .sbox_word_in(b_sin), .busy(b_busy),
    .expansion_done(b_done), .num_rounds(b_nr));

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] subword(input logic [31:0] x);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) begin
      r[8*i +: 8] = SBOX[2047 - 8*int'(x[8*i +: 8]) -: 8];
    end
    return r;
  endfunction

  // S-box models: valid only in the sampling cycle, garbage otherwise
  bit          arm_a = 0, arm_b = 0;
  int          cnt_a = 0, cnt_b = 0;
  logic [31:0] pend_a, pend_b;

  always @(negedge clk) begin
    if (arm_a) cnt_a--;
    if (arm_a && cnt_a == 0) begin
      a_sin = pend_a;
      arm_a = 0;
    end else a_sin = $urandom;
    if (a_req) begin
      arm_a = 1; cnt_a = 1; pend_a = subword(a_sw);
    end
  end

  always @(negedge clk) begin
    if (arm_b) cnt_b--;
    if (arm_b && cnt_b == 0) begin
      b_sin = pend_b;
      arm_b = 0;
    end else b_sin = $urandom;
    if (b_req) begin
      arm_b = 1; cnt_b = 3; pend_b = subword(b_sw);
    end
  end

  exp_t         e;
  logic [127:0] rk;
  logic [3:0]   nrv;
  logic         bz, dn, rqv;
  logic [31:0]  swv;
  int           np;
  int           dexp;
  bit           ok;

  always @(negedge clk) begin
    if (a_req) npa++;
    if (b_req) npb++;
    if (a_done && !pda) begin
      checks++;
      if (dqa.size() == 0) begin
        errors++;
        $display("FAIL done_a: rose at cycle %0d, required none", cyc);
      end else begin
        dexp = dqa.pop_front();
        if (dexp != cyc) begin
          errors++;
          $display("FAIL done_a: rose at cycle %0d, required %0d", cyc, dexp);
        end
      end
    end else if (dqa.size() > 0 && dqa[0] < cyc) begin
      checks++; errors++;
      $display("FAIL done_a: absent at cycle %0d, required %0d", cyc, dqa[0]);
      dqa.delete(0);
    end
    pda = a_done;
    if (b_done && !pdb) begin
      checks++;
      if (dqb.size() == 0) begin
        errors++;
        $display("FAIL done_b: rose at cycle %0d, required none", cyc);
      end else begin
        dexp = dqb.pop_front();
        if (dexp != cyc) begin
          errors++;
          $display("FAIL done_b: rose at cycle %0d, required %0d", cyc, dexp);
        end
      end
    end else if (dqb.size() > 0 && dqb[0] < cyc) begin
      checks++; errors++;
      $display("FAIL done_b: absent at cycle %0d, required %0d", cyc, dqb[0]);
      dqb.delete(0);
    end
    pdb = b_done;
    while (rq.size() > 0 && rq[0].due <= cyc) begin
      e   = rq.pop_front();
      rk  = e.dut ? b_rk : a_rk;
      nrv = e.dut ? b_nr : a_nr;
      bz  = e.dut ? b_busy : a_busy;
      dn  = e.dut ? b_done : a_done;
      rqv = e.dut ? b_req : a_req;
      swv = e.dut ? b_sw : a_sw;
      np  = e.dut ? npb : npa;
      ok = (rk === e.key) && (nrv === e.nr) &&
           (bz === e.busy) && (dn === e.done);
      if (e.sb && (rqv !== 1'b0 || swv !== 32'h0)) ok = 0;
      if (e.pulses >= 0 && np != e.pulses) ok = 0;
      checks++;
      if (!ok) begin
        errors++;
        $display("FAIL %s: key=%h nr=%0d busy=%b done=%b req=%b sw=%h pulses=%0d required key=%h nr=%0d busy=%b done=%b pulses=%0d",
                 e.name, rk, nrv, bz, dn, rqv, swv, np,
                 e.key, e.nr, e.busy, e.done, e.pulses);
      end
    end
    if (fin) begin
      while (rq.size() > 0) begin
        e = rq.pop_front();
        checks++; errors++;
        $display("FAIL %s: never reached, required a check", e.name);
      end
      while (dqa.size() + dqb.size() > 0) begin
        checks++; errors++;
        $display("FAIL done_pending: completion never seen");
        if (dqa.size() > 0) dqa.delete(0);
        else dqb.delete(0);
      end
    end
  end

  task automatic expect_rd(input bit d, input logic [3:0] r,
                           input logic [127:0] k, input logic [3:0] n,
                           input bit b, input bit dn_, input int npx,
                           input string nm);
    exp_t x;
    sel_round = r;
    x.due = cyc + 1; x.dut = d; x.name = nm; x.key = k;
    x.nr = n; x.busy = b; x.done = dn_; x.sb = !b; x.pulses = npx;
    rq.push_back(x);
    @(negedge clk);
  endtask

  task automatic load(input bit d, input logic [1:0] kl,
                      input logic [255:0] k, input int n);
    key_len = kl;
    cipher_key = k;
    if (d) load_b = 1'b1;
    else load_a = 1'b1;
    if (n > 0) begin
      if (d) dqb.push_back(cyc + 1 + n);
      else dqa.push_back(cyc + 1 + n);
    end
    @(negedge clk);
    load_a = 1'b0;
    load_b = 1'b0;
  endtask

  task automatic wait_done(input bit d);
    for (int i = 0; i < 400; i++) begin
      if ((d ? b_done : a_done) == 1'b1) break;
      @(negedge clk);
    end
  endtask

  task automatic push_zero(input bit d, input string nm);
    exp_t x;
    x.due = cyc; x.dut = d; x.name = nm; x.key = 128'h0;
    x.nr = 4'd0; x.busy = 0; x.done = 0; x.sb = 1; x.pulses = -1;
    rq.push_back(x);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: run did not finish");
    $fatal(1);
  end

  int base;

  initial begin
    reset_n = 1'b0;
    load_a = 1'b0;
    load_b = 1'b0;
    key_len = 2'd0;
    cipher_key = '0;
    sel_round = 4'd0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    expect_rd(0, 0, 128'h0, 0, 0, 0, -1, "reset_a");
    expect_rd(1, 0, 128'h0, 0, 0, 0, -1, "reset_b");

    load(0, 2'd0, K128, 50);
    expect_rd(0, 1, 128'h0, 10, 1, 0, -1, "a128_busy_read");
    wait_done(0);
    expect_rd(0, 0, K128[255:128], 10, 0, 1, -1, "a128_r0");
    expect_rd(0, 1, 128'ha0fafe1788542cb123a339392a6c7605,
              10, 0, 1, -1, "a128_r1");
    expect_rd(0, 10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6,
              10, 0, 1, -1, "a128_r10");
    expect_rd(0, 11, 128'h0, 10, 0, 1, -1, "a128_r11");

    load(0, 2'd3, K256, 0);
    expect_rd(0, 10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6,
              10, 0, 1, -1, "len3_r10");
    expect_rd(0, 1, 128'ha0fafe1788542cb123a339392a6c7605,
              10, 0, 1, -1, "len3_r1");

    load(0, 2'd1, K192, 54);
    wait_done(0);
    expect_rd(0, 0, K192[255:128], 12, 0, 1, -1, "a192_r0");
    expect_rd(0, 12, 128'he98ba06f448c773c8ecc720401002202,
              12, 0, 1, -1, "a192_r12");
    expect_rd(0, 13, 128'h0, 12, 0, 1, -1, "a192_r13");

    base = npa;
    load(0, 2'd2, K256, 65);
    wait_done(0);
    expect_rd(0, 14, 128'hfe4890d1e6188d0b046df344706c631e,
              14, 0, 1, base + 13, "a256_r14");
    expect_rd(0, 1, K256[127:0], 14, 0, 1, -1, "a256_r1");

    load(0, 2'd2, K256, 65);
    repeat (19) @(negedge clk);
    dqa.delete();
    load(0, 2'd0, K128, 50);
    wait_done(0);
    expect_rd(0, 10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6,
              10, 0, 1, -1, "restart_r10");
    expect_rd(0, 12, 128'h0, 10, 0, 1, -1, "restart_r12");

    load(1, 2'd0, K128, 70);
    wait_done(1);
    expect_rd(1, 10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6,
              10, 0, 1, -1, "lat3_r10");
    expect_rd(1, 1, 128'ha0fafe1788542cb123a339392a6c7605,
              10, 0, 1, -1, "lat3_r1");

    load(0, 2'd0, K128, 50);
    repeat (10) @(negedge clk);
    @(posedge clk);
    #1;
    reset_n = 1'b0;
    dqa.delete();
    push_zero(0, "async_reset_a");
    push_zero(1, "async_reset_b");
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    expect_rd(0, 0, 128'h0, 0, 0, 0, -1, "post_reset_a");
    expect_rd(0, 0, 128'h0, 0, 0, 0, -1, "post_reset_a2");

    fin = 1;
    @(negedge clk);
    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/aes_key_expander.md
# aes_key_expander

Parametrised AES key-schedule engine for AES-128, AES-192 and AES-256. The key length is selected at run time. The block expands a loaded cipher key into all round keys and stores them. It then serves any round key by index to the cipher datapath. SubWord uses the shared external S-box port, whose response latency is set by a parameter. The block sits between the key-load interface and the round datapath, in the same position as the AES-128-only key logic it generalises.

## Interface
- SBOX_LAT, 1: cycles from an S-box request to a valid `sbox_word_in`. Legal range is 1..4.
- clk  in  1  clock; all state changes on its rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- load_key  in  1  single-cycle pulse; captures `cipher_key` and `key_len` and starts expansion.
- key_len  in  2  0 = AES-128, 1 = AES-192, 2 = AES-256, 3 = reserved.
- cipher_key  in  256  key, left-aligned:
  - AES-128 uses [255:128].
  - AES-192 uses [255:64].
  - AES-256 uses all 256 bits.
  - Word w0 is the most-significant 32 bits.
- sel_round  in  4  index of the round key to read.
- round_key  out  128  registered read data, {w[4r], w[4r+1], w[4r+2], w[4r+3]} for round r.
- sbox_req  out  1  high for exactly one cycle per SubWord request.
- sbox_word_out  out  32  word to substitute; valid only while `sbox_req` = 1, otherwise 0.
- sbox_word_in  in  32  substituted word; sampled SBOX_LAT cycles after the request cycle.
- busy  out  1  expansion in progress.
- expansion_done  out  1  level signal; high from completion until the next accepted load or reset.
- num_rounds  out  4  Nr of the loaded key: 10, 12 or 14; 0 after reset.

## Operation
- Key length parameters:
  - Nk = 4, 6 or 8.
  - Nr = 10, 12 or 14.
  - Total words = 4(Nr+1), i.e. 44, 52 or 60.
  - Storage holds 60 x 32-bit words.
- Load:
  - On an edge where `load_key` = 1 and `key_len` != 3, the block writes w0..w(Nk-1), latches Nk/Nr, sets `busy` = 1 and clears `expansion_done`.
  - If `key_len` = 3, the load is ignored entirely and all state is unchanged.
- Word generation covers i = Nk .. 4(Nr+1)-1, one word at a time, in order:
  - If i mod Nk = 0: temp = SubWord(RotWord(w[i-1])) ^ {Rcon[i/Nk], 24'h0}.
  - Else if Nk = 8 and i mod 8 = 4: temp = SubWord(w[i-1]).
  - Else: temp = w[i-1].
  - Then w[i] = w[i-Nk] ^ temp.
- Rcon sequence: 01, 02, 04, 08, 10, 20, 40, 80, 1b, 36. Rcon is generated internally by xtime; no table is needed beyond index 10.
- FSM:
  - IDLE -> GEN on an accepted load.
  - GEN, for a plain word: write the word; stay in GEN. Go to DONE after the last word.
  - GEN, for a word needing SubWord: assert `sbox_req` with `sbox_word_out` for one cycle, then go to SWAIT.
  - SWAIT: count SBOX_LAT-1 further cycles. On the last cycle, sample `sbox_word_in`, write the word, and return to GEN (or go to DONE after the last word).
  - DONE: `busy` = 0, `expansion_done` = 1. Stay until the next load.
- Read path:
  - `round_key` is registered from `sel_round`.
  - It reads 0 while `busy` = 1, when `sel_round` > `num_rounds`, or after reset.
- A `load_key` accepted while busy aborts the current expansion and restarts with the new key. No partial words from the old key are ever readable.
- `sbox_word_in` is ignored in every cycle except the sampling cycle.

## Timing
- Reset values:
  - round_key = 0, sbox_req = 0, sbox_word_out = 0.
  - busy = 0, expansion_done = 0, num_rounds = 0.
  - FSM in IDLE; the word store is cleared.
- Reset asserted mid-expansion aborts immediately. A new load is required after release.
- Cost per generated word: 1 cycle for a plain word, SBOX_LAT+1 cycles for a SubWord word.
- Completion: let E0 be the load edge. `expansion_done` rises and `busy` falls at E0 + N cycles, where N is:
  - AES-128: 30 + 10(SBOX_LAT+1).
  - AES-192: 38 + 8(SBOX_LAT+1).
  - AES-256: 39 + 13(SBOX_LAT+1).
- With SBOX_LAT = 1, N = 50 / 54 / 65.
- Read latency: `round_key` reflects `sel_round` one edge after it is sampled.
- Simultaneous `load_key` and expansion completion on the same edge: the load wins, so `busy` stays 1 and `expansion_done` stays 0.

## Test plan
- AES-128, key 2b7e151628aed2a6abf7158809cf4f3c, SBOX_LAT=1:
  - `expansion_done` at E0+50.
  - Round 1 = a0fafe1788542cb123a339392a6c7605.
  - Round 10 = d014f9a8c9ee2589e13f0cc8b6630ca6.
  - `num_rounds` = 10.
- AES-192, key 8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b:
  - Done at E0+54.
  - Round 12 = e98ba06f448c773c8ecc720401002202.
  - `sel_round` = 13 returns 0.
- AES-256, key 603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4:
  - Done at E0+65.
  - Round 14 = fe4890d1e6188d0b046df344706c631e.
  - Exactly 13 `sbox_req` pulses observed.
- SBOX_LAT=3 instance, AES-128 vector above:
  - Done at E0+70.
  - Round 10 unchanged.
  - `sbox_word_in` driven with garbage outside the sampling cycles has no effect.
- Restart behaviour:
  - Load AES-256, then reload the AES-128 key at E0+20. Expect done at reload+50 and the correct AES-128 round 10.
  - `key_len` = 3 load while done leaves keys and outputs unchanged.
- Reset and busy reads:
  - Drop `reset_n` mid-expansion: all outputs 0 asynchronously, and `round_key` stays 0 after release.
  - Reads while `busy` = 1 return 0.
